// File: rtl/sync_gray_ptr_r.sv
// Read-domain synchroniser for a Gray-coded FIFO write pointer, with registered
// binary decode, per-cycle advance, warm-up qualification and illegal-step detection.
module sync_gray_ptr_r #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [WIDTH-1:0] wptr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] rq_gptr,
    output logic [WIDTH-1:0] rq_bptr,
    output logic [WIDTH-1:0] rq_delta,
    output logic             rq_changed,
    output logic             rq_valid,
    output logic             gray_err
);

    localparam logic [2:0] WARM_MAX = 3'(STAGES);

    logic [WIDTH-1:0] sync_r [STAGES];
    logic [WIDTH-1:0] prev_g_r;
    logic [2:0]       warm_cnt_r;

    logic [WIDTH-1:0] bin_s;
    logic [WIDTH-1:0] delta_s;
    logic             changed_s;
    logic             step_err_s;
    logic             valid_next_s;
    logic             err_next_s;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit of d is set (clearing the lowest set bit leaves something).
    function automatic logic multi_bit(input logic [WIDTH-1:0] d);
        return (d & (d - {{(WIDTH-1){1'b0}}, 1'b1})) != {WIDTH{1'b0}};
    endfunction

    assign rq_gptr = sync_r[STAGES-1];

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= wptr;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Decode, advance, warm-up qualification and error evaluation for this edge.
    always_comb begin
        bin_s        = gray2bin(rq_gptr);
        valid_next_s = (warm_cnt_r == WARM_MAX);
        delta_s      = {WIDTH{1'b0}};
        changed_s    = 1'b0;
        step_err_s   = 1'b0;
        // Until the chain has filled, the first sample may jump arbitrarily from 0.
        if (rq_valid) begin
            delta_s    = bin_s - rq_bptr;
            changed_s  = (bin_s != rq_bptr);
            step_err_s = multi_bit(rq_gptr ^ prev_g_r);
        end else begin
            delta_s    = {WIDTH{1'b0}};
            changed_s  = 1'b0;
            step_err_s = 1'b0;
        end
        // A fresh error wins over a simultaneous clear.
        if (step_err_s) begin
            err_next_s = 1'b1;
        end else if (err_clr) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = gray_err;
        end
    end

    // Saturating warm-up counter and sticky valid flag.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            warm_cnt_r <= 3'd0;
            rq_valid   <= 1'b0;
        end else begin
            if (warm_cnt_r != WARM_MAX) begin
                warm_cnt_r <= warm_cnt_r + 3'd1;
            end
            rq_valid <= valid_next_s;
        end
    end

    // Registered decode outputs and error flag.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rq_bptr    <= {WIDTH{1'b0}};
            rq_delta   <= {WIDTH{1'b0}};
            rq_changed <= 1'b0;
            prev_g_r   <= {WIDTH{1'b0}};
            gray_err   <= 1'b0;
        end else begin
            rq_bptr    <= bin_s;
            rq_delta   <= delta_s;
            rq_changed <= changed_s;
            prev_g_r   <= rq_gptr;
            gray_err   <= err_next_s;
        end
    end

endmodule

// File: tb/tb_sync_gray_ptr_r.sv
// Scoreboard bench: a history-of-samples model predicts every output after each rclk edge.
module tb_sync_gray_ptr_r;

    localparam int W = 5;
    localparam int S = 2;

    logic         rclk = 1'b0;
    logic         rrst;
    logic [W-1:0] wptr;
    logic         err_clr;
    logic [W-1:0] rq_gptr, rq_bptr, rq_delta;
    logic         rq_changed, rq_valid, gray_err;

    sync_gray_ptr_r #(.WIDTH(W), .STAGES(S)) dut (
        .rclk(rclk), .rrst(rrst), .wptr(wptr), .err_clr(err_clr),
        .rq_gptr(rq_gptr), .rq_bptr(rq_bptr), .rq_delta(rq_delta),
        .rq_changed(rq_changed), .rq_valid(rq_valid), .gray_err(gray_err)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [W-1:0] gptr;
        logic [W-1:0] bptr;
        logic [W-1:0] delta;
        logic         changed;
        logic         valid;
        logic         err;
    } exp_t;

    exp_t         scb[$];
    logic [W-1:0] hist[$];
    logic         exp_err;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W-1:0] g(input int i);
        logic [W-1:0] v;
        v = W'(i);
        return v ^ (v >> 1);
    endfunction

    // Inverse Gray by search over all codes.
    function automatic int g2i(input logic [W-1:0] x);
        for (int i = 0; i < (1 << W); i++) begin
            if (g(i) == x) return i;
        end
        return -1;
    endfunction

    // Pointer sampled at edge k after reset release; everything before is the reset value.
    function automatic logic [W-1:0] hget(input int k);
        if (k >= 1) return hist[k-1];
        return '0;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Called on a falling edge: apply inputs, predict the state after the coming rising edge.
    task automatic drive(input logic [W-1:0] gv, input logic clr);
        exp_t         e;
        int           n;
        logic [W-1:0] gc, gp, bc, bp;
        logic         valid_before;
        wptr    = gv;
        err_clr = clr;
        hist.push_back(gv);
        n            = hist.size();
        valid_before = (n - 1) >= (S + 1);
        gc           = hget(n - S);
        gp           = hget(n - S - 1);
        bc           = W'(g2i(gc));
        bp           = W'(g2i(gp));
        e.gptr    = hget(n - S + 1);
        e.bptr    = bc;
        e.valid   = n >= (S + 1);
        e.delta   = valid_before ? W'(bc - bp) : '0;
        e.changed = valid_before && (bc != bp);
        if (valid_before && ($countones(gc ^ gp) > 1)) exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;
        e.err = exp_err;
        scb.push_back(e);
        @(negedge rclk);
    endtask

    task automatic hold_ptr(input int p, input int cycles);
        for (int i = 0; i < cycles; i++) drive(g(p), 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rrst = 1'b1;
        hist.delete();
        exp_err = 1'b0;
        repeat (cycles) @(negedge rclk);
        rrst = 1'b0;
    endtask

    // Monitor: every edge out of reset, compare against the oldest prediction.
    always @(posedge rclk) begin
        exp_t e;
        #1;
        if (!rrst && scb.size() > 0) begin
            e = scb.pop_front();
            chk("rq_gptr", rq_gptr, e.gptr);
            chk("rq_bptr", rq_bptr, e.bptr);
            chk("rq_delta", rq_delta, e.delta);
            chk("rq_changed", rq_changed, e.changed);
            chk("rq_valid", rq_valid, e.valid);
            chk("gray_err", gray_err, e.err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int cur;
        int r;
        rrst    = 1'b1;
        wptr    = g(7);
        err_clr = 1'b0;
        exp_err = 1'b0;
        repeat (3) @(negedge rclk);
        chk("reset_gptr", rq_gptr, 0);
        chk("reset_bptr", rq_bptr, 0);
        chk("reset_valid", rq_valid, 0);
        chk("reset_err", gray_err, 0);
        rrst = 1'b0;

        // Warm-up, latency and single increment.
        hold_ptr(7, 6);
        hold_ptr(8, 5);

        // Full wrap through 31 -> 0.
        hold_ptr(30, 4);
        hold_ptr(31, 4);
        hold_ptr(0, 4);
        hold_ptr(1, 4);

        // Fast writer: only the last of three changes is sampled.
        hold_ptr(4, 4);
        wptr = g(5);
        #1 wptr = g(6);
        #1 drive(g(6), 1'b0);
        hold_ptr(6, 4);
        drive(g(6), 1'b1);
        hold_ptr(6, 2);

        // Illegal 2-bit step, then clear, then clear coinciding with a new error.
        drive(5'b00000, 1'b0);
        drive(5'b00000, 1'b0);
        drive(5'b00000, 1'b0);
        for (int i = 0; i < 5; i++) drive(5'b00011, 1'b0);
        drive(5'b00011, 1'b1);
        drive(5'b00011, 1'b0);
        drive(5'b01100, 1'b0);
        drive(5'b01100, 1'b0);
        drive(5'b01100, 1'b1);
        for (int i = 0; i < 3; i++) drive(5'b01100, 1'b0);
        drive(5'b01100, 1'b1);

        // Random walk with occasional corrupt samples and clears.
        cur = 9;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8) cur = cur;
            else if (r < 16) cur = (cur + 1) % (1 << W);
            else if (r < 18) cur = (cur + 2) % (1 << W);
            else cur = $urandom_range(0, (1 << W) - 1);
            drive(g(cur), ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        // Async reset between edges with rq_bptr = 12.
        hold_ptr(12, 6);
        #2 rrst = 1'b1;
        hist.delete();
        exp_err = 1'b0;
        #1;
        chk("async_gptr", rq_gptr, 0);
        chk("async_bptr", rq_bptr, 0);
        chk("async_delta", rq_delta, 0);
        chk("async_changed", rq_changed, 0);
        chk("async_valid", rq_valid, 0);
        chk("async_err", gray_err, 0);
        chk("async_queue", scb.size(), 0);
        do_reset(3);
        hold_ptr(12, 6);
        hold_ptr(13, 4);

        @(posedge rclk);
        #2;
        chk("scoreboard_drained", scb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
